// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/word widths, JMP opcode, fetch FSM
// states and the IF/ID pipeline bundle used by fetch and decode.
package cpu_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;
    localparam int OP_W    = 5;

    localparam logic [OP_W-1:0]    OP_JMP    = 5'b11100;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_BUBBLE
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               valid;
        logic               pred_taken;
    } ifid_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: redirect, hold on stall, early JMP target, or PC+1.
// Ports: pc_i, redirect_i/redirect_addr_i, stall_i, op_i/target_i
// (fields of the fetched word) -> pc_next_o, jmp_taken_o.
// Early JMP follow is enabled by the FETCH_EARLY_JMP_EN macro.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    input  logic              stall_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              jmp_taken_o
);

`ifdef FETCH_EARLY_JMP_EN
    localparam logic EARLY_JMP = 1'b1;
`else
    localparam logic EARLY_JMP = 1'b0;
`endif

    logic advance;

    assign advance     = !redirect_i && !stall_i;
    assign jmp_taken_o = EARLY_JMP && advance && (op_i == OP_JMP);

    // Redirect and stall may both be high; redirect must win.
    always_comb begin
        pc_next_o = pc_i + 1'b1;
        if (redirect_i) begin
            pc_next_o = redirect_addr_i;
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end else if (jmp_taken_o) begin
            pc_next_o = target_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the instruction memory address
// and registers the returned word into the IF/ID bundle for decode.
// Ports: clock, reset_n (sync, active low), pc_addr -> memory,
// instr_in <- memory, stall, redirect_valid/redirect_addr from
// downstream; ifid_* to decode; fetch_count = accepted instructions.
// Optional macro FETCH_EARLY_JMP_EN follows JMPs at fetch time.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid,
    output logic               ifid_pred_taken,
    output logic [CNT_W-1:0]   fetch_count
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              jmp_taken;
    ifid_t             ifid_q;
    logic [CNT_W-1:0]  cnt_q;
    fetch_state_e      state_q;

    pc_next_sel u_pc_next_sel (
        .pc_i            (pc_q),
        .redirect_i      (redirect_valid),
        .redirect_addr_i (redirect_addr),
        .stall_i         (stall),
        .op_i            (instr_in[INSTR_W-1 -: OP_W]),
        .target_i        (instr_in[ADDR_W-1:0]),
        .pc_next_o       (pc_d),
        .jmp_taken_o     (jmp_taken)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_RESET;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                // Flush; ifid_q.pc keeps its old value.
                ifid_q.instr      <= NOP_INSTR;
                ifid_q.valid      <= 1'b0;
                ifid_q.pred_taken <= 1'b0;
                state_q           <= ST_BUBBLE;
            end else if (stall) begin
                if (state_q == ST_RESET) begin
                    state_q <= ST_RUN;
                end
            end else begin
                ifid_q.instr      <= instr_in;
                ifid_q.pc         <= pc_q + 1'b1;
                ifid_q.valid      <= 1'b1;
                ifid_q.pred_taken <= jmp_taken;
                cnt_q             <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                state_q           <= ST_RUN;
            end
        end
    end

    assign pc_addr         = pc_q;
    assign ifid_instr      = ifid_q.instr;
    assign ifid_pc         = ifid_q.pc;
    assign ifid_valid      = ifid_q.valid;
    assign ifid_pred_taken = ifid_q.pred_taken;
    assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver pushes model results into
// a queue, a monitor pops and compares after every rising edge.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] pc_addr;
    logic [18:0] instr_in;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_addr;
    logic [18:0] ifid_instr;
    logic [11:0] ifid_pc;
    logic        ifid_valid;
    logic        ifid_pred_taken;
    logic [15:0] fetch_count;

`ifdef FETCH_EARLY_JMP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [18:0] mem [4096];

    assign instr_in = mem[pc_addr];

    fetch_stage dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pc_addr         (pc_addr),
        .instr_in        (instr_in),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_valid      (ifid_valid),
        .ifid_pred_taken (ifid_pred_taken),
        .fetch_count     (fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          pc;
        logic [18:0] instr;
        int          ipc;
        bit          v;
        bit          pred;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_pc;
    logic [18:0] m_instr;
    int          m_ipc;
    bit          m_v;
    bit          m_pred;
    int          m_cnt;

    function automatic void model_step(bit rn, bit st, bit rv, int ra);
        logic [18:0] w;
        if (!rn) begin
            m_pc = 0; m_instr = '0; m_ipc = 0;
            m_v = 0; m_pred = 0; m_cnt = 0;
        end else if (rv) begin
            m_pc = ra; m_instr = '0; m_v = 0; m_pred = 0;
        end else if (!st) begin
            w = mem[m_pc];
            m_instr = w;
            m_ipc = (m_pc + 1) % 4096;
            m_v = 1;
            m_pred = EARLY && (w[18:14] == 5'b11100);
            m_pc = m_pred ? int'(w[11:0]) : (m_pc + 1) % 4096;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endfunction

    task automatic cyc(bit rn, bit st, bit rv, int ra);
        exp_t e;
        @(negedge clock);
        reset_n = rn;
        stall = st;
        redirect_valid = rv;
        redirect_addr = ra[11:0];
        model_step(rn, st, rv, ra);
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc;
        e.v = m_v; e.pred = m_pred; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h",
                     nm, $time, act, exp);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_addr", 32'(pc_addr), 32'(e.pc));
                chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
                chk("ifid_valid", 32'(ifid_valid), 32'(e.v));
                chk("ifid_pred", 32'(ifid_pred_taken), 32'(e.pred));
                chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
                if (e.v)
                    chk("ifid_pc", 32'(ifid_pc), 32'(e.ipc));
            end
        end
    end

    function automatic logic [18:0] rand_word();
        logic [18:0] w;
        w = 19'($urandom);
        if (w[18:14] == 5'b11100) w[18] = 1'b0;
        return w;
    endfunction

    initial begin : stim
        int n;
        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = rand_word();
        // Sprinkle JMPs outside the directed region
        for (int i = 0; i < 40; i++) begin
            n = 20 + int'($urandom_range(0, 4000));
            mem[n] = {5'b11100, 2'b00, 12'($urandom)};
        end
        mem[9] = {5'b11100, 2'b00, 12'd2};

        // Reset then three advances
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // Redirect to 5, bubble, stall 4, release
        cyc(1, 0, 1, 5);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        // Redirect with simultaneous stall
        cyc(1, 1, 1, 10);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // Wrap at top of memory
        cyc(1, 0, 1, 4095);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // JMP at 9
        cyc(1, 0, 1, 9);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // Reset mid-stream
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 100);
        cyc(1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rn, st, rv;
            int ra;
            rn = ($urandom_range(0, 199) != 0);
            st = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 9) == 0);
            ra = ($urandom_range(0, 7) == 0) ? 4095
                 : int'($urandom_range(0, 4095));
            cyc(rn, st, rv, ra);
        end

        // Counter saturation: run past 65535 accepted fetches
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 7);
        cyc(0, 0, 0, 0);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clock);
            n++;
        end
        #3;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
